ras_ckpt_stack: RTL
===================

// Module: ras_ckpt_stack
// PURPOSE
//  Return-address stack for the frontend branch predictor, sized by the RASDepth config field (default 2).
//  Circular storage: oldest entry is overwritten on overflow.
//  Single-level checkpoint/restore repairs pointer state after a mispredicted call/return.
//  Consumer: frontend next-PC mux, which uses top_o.valid to accept a return prediction.
// PARAMETERS
//  DEPTH    2   entries; >=2, power of two not required
//  VLEN     64  return-address width (bits)
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        synchronous reset, active-high
//  flush_i      in   1        empty the stack (count=0); entries left stale
//  push_i       in   1        call: push data_i
//  pop_i        in   1        return: pop top
//  data_i       in   VLEN     address pushed on push_i
//  ckpt_i       in   1        snapshot {ptr,count,top entry}
//  restore_i    in   1        reload snapshot
//  top_o        out  1+VLEN   {valid, addr}: current top, combinational from state
//  count_o      out  $clog2(DEPTH+1)  live entries
//  overflow_o   out  1        1-cycle pulse: push overwrote a live entry
// BEHAVIOUR
//  Reset: ptr=0, count=0, all entries 0, snapshot 0, overflow_o=0, top_o.valid=0.
//  top_o = {count!=0, mem[ptr]}. Pop reads top_o in the same cycle; state updates at the edge.
//  Priority per cycle: rst_i > flush_i > restore_i > push/pop. ckpt_i is independent of this order.
//  push only: ptr=(ptr+1)%DEPTH; mem[new ptr]=data_i; count=min(count+1,DEPTH).
//    If count==DEPTH before the push, overflow_o=1 next cycle.
//  pop only, count>0: ptr=(ptr-1+DEPTH)%DEPTH; count-=1.
//  pop only, count==0: no state change; top_o.valid stays 0.
//  push+pop, count>0: mem[ptr]=data_i (replace top); ptr and count unchanged.
//  push+pop, count==0: treated as push only.
//  Pointer wrap uses an explicit compare with DEPTH-1, not modulo via bit truncation.
//  ckpt_i: snapshot <= {ptr, count, mem[ptr]} taken from pre-edge state.
//    Same-cycle push/pop still applies to the live state.
//  restore_i: ptr, count and mem[snap.ptr] <= snapshot. push/pop/ckpt in that cycle are ignored.
//  flush_i: count=0, ptr unchanged, snapshot unchanged. push/pop/restore in that cycle are ignored.
//  Reset mid-operation: all state returns to reset values on the next edge regardless of other inputs.
//  No X on outputs after reset; DEPTH==1 is illegal (elaboration assertion).
// STRUCTURE
//  Shared package (frontend pkg): ras_t {logic valid; logic [VLEN-1:0] ra;}.
//    Also ras_snap_t {ptr, count, ra}; DEPTH is taken from cva6_cfg.RASDepth at instantiation.
//  Single flat module.
//  The ptr increment/decrement wrap helper is a local function, not a sub-module.
//  Storage is flops; no SRAM macro.
// TESTING
//  1 Reset, then push 0x100, push 0x200 (DEPTH=2):
//    top_o={1,0x200}, count_o=2, overflow_o=0.
//  2 Continue: push 0x300:
//    overflow_o pulses 1 cycle; top_o=0x300; after pop, top_o=0x200; after a second pop, count_o=0.
//  3 Empty stack, pop:
//    top_o.valid=0, count_o=0, no ptr change; then push+pop 0x40 same cycle gives count_o=1, top 0x40.
//  4 Stack {0x100,0x200}, push+pop 0x500:
//    count_o=2, top 0x500; next pop gives top 0x100.
//  5 Stack {0x100}, ckpt_i; push 0xA, push 0xB, pop; restore_i:
//    count_o=1, top_o={1,0x100}; ckpt+push in the same cycle snapshots the pre-push state.
//  6 Assert flush_i together with push_i and restore_i: count_o=0, valid=0.
//    Assert rst_i mid-burst: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ras_ckpt_stack_pkg.sv
// ============================================================================
// Module      : ras_ckpt_stack_pkg
// Description : Shared types and defaults for the frontend return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ras_ckpt_stack_pkg;

    localparam int unsigned RAS_DEPTH_DEFAULT = 2;
    localparam int unsigned RAS_VLEN_DEFAULT  = 64;
    localparam int unsigned RAS_PTR_W_DEFAULT = $clog2(RAS_DEPTH_DEFAULT);
    localparam int unsigned RAS_CNT_W_DEFAULT = $clog2(RAS_DEPTH_DEFAULT + 1);

    typedef struct packed {
        logic                        valid;
        logic [RAS_VLEN_DEFAULT-1:0] ra;
    } ras_t;

    typedef struct packed {
        logic [RAS_PTR_W_DEFAULT-1:0] ptr;
        logic [RAS_CNT_W_DEFAULT-1:0] count;
        logic [RAS_VLEN_DEFAULT-1:0]  ra;
    } ras_snap_t;

    // Resolved per-cycle operation after applying flush/restore/push/pop priority.
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_FLUSH   = 3'd4,
        OP_RESTORE = 3'd5
    } ras_op_e;

endpackage

`default_nettype wire

// File: rtl/ras_ckpt_stack.sv
// ============================================================================
// Module      : ras_ckpt_stack
// Description : Circular return-address stack with single-level checkpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_ckpt_stack
    import ras_ckpt_stack_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
    parameter int unsigned VLEN  = RAS_VLEN_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [VLEN-1:0]              data_i,
    input  logic                         ckpt_i,
    input  logic                         restore_i,
    output logic [VLEN:0]                top_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);

    localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_max = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    if (DEPTH < 2) begin : g_depth_check
        $error("ras_ckpt_stack: DEPTH must be at least 2");
    end

    logic [VLEN-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;

    logic [c_ptr_w-1:0] r_snap_ptr;
    logic [c_cnt_w-1:0] r_snap_count;
    logic [VLEN-1:0]    r_snap_ra;

    ras_op_e            w_op;
    logic               w_empty;
    logic [c_ptr_w-1:0] w_ptr_inc;
    logic [c_ptr_w-1:0] w_ptr_dec;

    // Explicit compare keeps the wrap correct for non-power-of-two depths.
    function automatic logic [c_ptr_w-1:0] f_wrap(input logic [c_ptr_w-1:0] p,
                                                  input logic               up);
        if (up) begin
            return (p == c_ptr_max) ? '0 : p + c_ptr_one;
        end
        return (p == '0) ? c_ptr_max : p - c_ptr_one;
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_ptr_inc = f_wrap(r_ptr, 1'b1);
    assign w_ptr_dec = f_wrap(r_ptr, 1'b0);

    always_comb begin
        w_op = OP_IDLE;
        if (flush_i) begin
            w_op = OP_FLUSH;
        end else if (restore_i) begin
            w_op = OP_RESTORE;
        end else if (push_i && pop_i && !w_empty) begin
            w_op = OP_REPLACE;
        end else if (push_i) begin
            w_op = OP_PUSH;
        end else if (pop_i && !w_empty) begin
            w_op = OP_POP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr        <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_snap_ptr   <= '0;
            r_snap_count <= '0;
            r_snap_ra    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_overflow <= 1'b0;

            // Snapshot always reflects pre-edge state; only a live restore suppresses it.
            if (ckpt_i && (w_op != OP_RESTORE)) begin
                r_snap_ptr   <= r_ptr;
                r_snap_count <= r_count;
                r_snap_ra    <= r_mem[r_ptr];
            end

            case (w_op)
                OP_FLUSH: begin
                    r_count <= '0;
                end
                OP_RESTORE: begin
                    r_ptr             <= r_snap_ptr;
                    r_count           <= r_snap_count;
                    r_mem[r_snap_ptr] <= r_snap_ra;
                end
                OP_REPLACE: begin
                    r_mem[r_ptr] <= data_i;
                end
                OP_PUSH: begin
                    r_ptr            <= w_ptr_inc;
                    r_mem[w_ptr_inc] <= data_i;
                    if (r_count == c_cnt_max) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + c_cnt_one;
                    end
                end
                OP_POP: begin
                    r_ptr   <= w_ptr_dec;
                    r_count <= r_count - c_cnt_one;
                end
                default: begin
                end
            endcase
        end
    end

    assign top_o      = {!w_empty, r_mem[r_ptr]};
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule

`default_nettype wire
